// File: rtl/lsu_bus_pkg.sv
// ============================================================================
// Module : lsu_bus_pkg
// Brief  : Shared state encoding and watchdog default for the LSU bus bridge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_bus_pkg;

  typedef enum logic [1:0] {
    CIRNO_LSU_ST_IDLE = 2'd0,
    CIRNO_LSU_ST_CMD  = 2'd1,
    CIRNO_LSU_ST_RSP  = 2'd2,
    CIRNO_LSU_ST_DONE = 2'd3
  } lsu_state_e;

  localparam int CIRNO_LSU_TO_DEF = 255;

endpackage

`default_nettype wire

// File: rtl/lsu_wdog.sv
// ============================================================================
// Module : lsu_wdog
// Brief  : Clear/increment/expire response watchdog counter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_wdog #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  // A zero timeout disables the counter entirely; expire never asserts.
  localparam bit              c_en   = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] c_last = c_en ? TO_W'(TIMEOUT_CYC - 1) : '0;

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && c_en && !expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = c_en && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/lsu_bus.sv
// ============================================================================
// Module : lsu_bus
// Brief  : Single-outstanding load/store bridge onto a split cmd/rsp bus
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_bus
  import lsu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = CIRNO_LSU_TO_DEF,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_ex4ls_val,
  output logic        hs_ls4ex_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_err,
  output logic        o_bus_cmd_val,
  input  logic        i_bus_cmd_rdy,
  output logic [31:0] o_bus_adr,
  output logic [31:0] o_bus_wdat,
  output logic [3:0]  o_bus_wen,
  output logic        o_bus_read,
  input  logic        i_bus_rsp_val,
  output logic        o_bus_rsp_rdy,
  input  logic [31:0] i_bus_rdat,
  input  logic        i_bus_err
);

  lsu_state_e  r_state;
  logic        r_ls_rdy;
  logic [31:0] r_ls_rdat;
  logic        r_ls_err;
  logic        r_cmd_val;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [3:0]  r_wen;
  logic        r_read;
  logic        r_rsp_rdy;

  logic        w_wd_clr;
  logic        w_wd_inc;
  logic        w_wd_expire;

  assign w_wd_clr = (r_state == CIRNO_LSU_ST_CMD) && i_bus_cmd_rdy;
  assign w_wd_inc = (r_state == CIRNO_LSU_ST_RSP) && !i_bus_rsp_val;

  lsu_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_wd_clr),
    .inc    (w_wd_inc),
    .expire (w_wd_expire)
  );

  // Completion outputs default low each cycle so they only carry data in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CIRNO_LSU_ST_IDLE;
      r_ls_rdy  <= 1'b0;
      r_ls_rdat <= '0;
      r_ls_err  <= 1'b0;
      r_cmd_val <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_wen     <= '0;
      r_read    <= 1'b0;
      r_rsp_rdy <= 1'b1;
    end else begin
      r_ls_rdy  <= 1'b0;
      r_ls_rdat <= '0;
      r_ls_err  <= 1'b0;
      case (r_state)
        CIRNO_LSU_ST_IDLE: begin
          if (hs_ex4ls_val) begin
            r_adr     <= i_ls_adr;
            r_wdat    <= i_ls_wdat;
            r_wen     <= i_ls_ren ? 4'b0000 : i_ls_wen;
            r_read    <= i_ls_ren;
            r_rsp_rdy <= 1'b0;
            if (i_ls_ren && (i_ls_wen != 4'b0000)) begin
              r_ls_err <= 1'b1;
              r_ls_rdy <= 1'b1;
              r_state  <= CIRNO_LSU_ST_DONE;
            end else if (!i_ls_ren && (i_ls_wen == 4'b0000)) begin
              r_ls_rdy <= 1'b1;
              r_state  <= CIRNO_LSU_ST_DONE;
            end else begin
              r_cmd_val <= 1'b1;
              r_state   <= CIRNO_LSU_ST_CMD;
            end
          end
        end
        CIRNO_LSU_ST_CMD: begin
          if (i_bus_cmd_rdy) begin
            r_cmd_val <= 1'b0;
            r_rsp_rdy <= 1'b1;
            r_state   <= CIRNO_LSU_ST_RSP;
          end
        end
        CIRNO_LSU_ST_RSP: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (i_bus_rsp_val) begin
            r_ls_rdat <= r_read ? i_bus_rdat : 32'h0;
            r_ls_err  <= i_bus_err;
            r_ls_rdy  <= 1'b1;
            r_rsp_rdy <= 1'b0;
            r_state   <= CIRNO_LSU_ST_DONE;
          end else if (w_wd_expire) begin
            r_ls_err  <= 1'b1;
            r_ls_rdy  <= 1'b1;
            r_rsp_rdy <= 1'b0;
            r_state   <= CIRNO_LSU_ST_DONE;
          end
        end
        CIRNO_LSU_ST_DONE: begin
          r_rsp_rdy <= 1'b1;
          r_state   <= CIRNO_LSU_ST_IDLE;
        end
        default: begin
          r_rsp_rdy <= 1'b1;
          r_state   <= CIRNO_LSU_ST_IDLE;
        end
      endcase
    end
  end

  assign hs_ls4ex_rdy  = r_ls_rdy;
  assign o_ls_rdat     = r_ls_rdat;
  assign o_ls_err      = r_ls_err;
  assign o_bus_cmd_val = r_cmd_val;
  assign o_bus_adr     = r_adr;
  assign o_bus_wdat    = r_wdat;
  assign o_bus_wen     = r_wen;
  assign o_bus_read    = r_read;
  assign o_bus_rsp_rdy = r_rsp_rdy;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus.sv
// ============================================================================
// Module : tb_lsu_bus
// Brief  : Directed plus randomized self-checking bench for lsu_bus
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        hs_ex4ls_val;
  logic        hs_ls4ex_rdy;
  logic [31:0] i_ls_adr;
  logic [31:0] i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic [31:0] o_ls_rdat;
  logic        o_ls_err;
  logic        o_bus_cmd_val;
  logic        i_bus_cmd_rdy;
  logic [31:0] o_bus_adr;
  logic [31:0] o_bus_wdat;
  logic [3:0]  o_bus_wen;
  logic        o_bus_read;
  logic        i_bus_rsp_val;
  logic        o_bus_rsp_rdy;
  logic [31:0] i_bus_rdat;
  logic        i_bus_err;

  int checks = 0;
  int errors = 0;

  lsu_bus #(
    .TIMEOUT_CYC (TO),
    .TO_W        (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs_ex4ls_val  (hs_ex4ls_val),
    .hs_ls4ex_rdy  (hs_ls4ex_rdy),
    .i_ls_adr      (i_ls_adr),
    .i_ls_wdat     (i_ls_wdat),
    .i_ls_wen      (i_ls_wen),
    .i_ls_ren      (i_ls_ren),
    .o_ls_rdat     (o_ls_rdat),
    .o_ls_err      (o_ls_err),
    .o_bus_cmd_val (o_bus_cmd_val),
    .i_bus_cmd_rdy (i_bus_cmd_rdy),
    .o_bus_adr     (o_bus_adr),
    .o_bus_wdat    (o_bus_wdat),
    .o_bus_wen     (o_bus_wen),
    .o_bus_read    (o_bus_read),
    .i_bus_rsp_val (i_bus_rsp_val),
    .o_bus_rsp_rdy (o_bus_rsp_rdy),
    .i_bus_rdat    (i_bus_rdat),
    .i_bus_err     (i_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rdy"},     64'(hs_ls4ex_rdy),  64'd0);
    chk({pfx, "_rdat"},    64'(o_ls_rdat),     64'd0);
    chk({pfx, "_err"},     64'(o_ls_err),      64'd0);
    chk({pfx, "_cmd_val"}, 64'(o_bus_cmd_val), 64'd0);
    chk({pfx, "_adr"},     64'(o_bus_adr),     64'd0);
    chk({pfx, "_wdat"},    64'(o_bus_wdat),    64'd0);
    chk({pfx, "_wen"},     64'(o_bus_wen),     64'd0);
    chk({pfx, "_read"},    64'(o_bus_read),    64'd0);
    chk({pfx, "_rsp_rdy"}, 64'(o_bus_rsp_rdy), 64'd1);
  endtask

  // One access, entered and left at a negedge while the DUT is idle.
  // stall = cycles the command waits before accept; d = response offset in RSP.
  task automatic do_access(input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] wen, input logic ren,
                           input int stall, input int d,
                           input logic [31:0] brdat, input logic berr);
    int          exp_lat;
    int          exp_cmds;
    logic [31:0] exp_rdat;
    logic        exp_err;
    int          cmd_cnt;
    int          off;
    bit          done;
    bit          last_cmd;
    bit          drove_rdy;

    // Reference outcome from the access rules, in cycles after the sampling edge.
    if (ren && wen != 4'd0) begin
      exp_cmds = 0; exp_lat = 1; exp_err = 1'b1; exp_rdat = 32'h0;
    end else if (!ren && wen == 4'd0) begin
      exp_cmds = 0; exp_lat = 1; exp_err = 1'b0; exp_rdat = 32'h0;
    end else begin
      exp_cmds = stall + 1;
      if (d < TO) begin
        exp_lat = 3 + stall + d; exp_err = berr; exp_rdat = ren ? brdat : 32'h0;
      end else begin
        exp_lat = 2 + stall + TO; exp_err = 1'b1; exp_rdat = 32'h0;
      end
    end

    hs_ex4ls_val = 1'b1;
    i_ls_adr = adr; i_ls_wdat = wdat; i_ls_wen = wen; i_ls_ren = ren;
    i_bus_cmd_rdy = 1'b0; i_bus_rsp_val = 1'b0;
    i_bus_rdat = brdat; i_bus_err = berr;
    cmd_cnt = 0; off = -1; done = 0; last_cmd = 0; drove_rdy = 0;

    for (int k = 1; k <= 60 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      if (last_cmd && drove_rdy) off = 0;
      else if (off >= 0) off++;
      i_bus_cmd_rdy = 1'b0; drove_rdy = 0;
      i_bus_rsp_val = 1'b0;
      if (hs_ls4ex_rdy) begin
        chk("latency", 64'(k), 64'(exp_lat));
        chk("ls_rdat", 64'(o_ls_rdat), 64'(exp_rdat));
        chk("ls_err", 64'(o_ls_err), 64'(exp_err));
        chk("cmd_cycles", 64'(cmd_cnt), 64'(exp_cmds));
        done = 1;
        hs_ex4ls_val = 1'b0;
      end else begin
        chk("quiet_outs", {31'd0, o_ls_err, o_ls_rdat}, 64'd0);
        if (o_bus_cmd_val) begin
          cmd_cnt++;
          chk("cmd_adr", 64'(o_bus_adr), 64'(adr));
          chk("cmd_wdat", 64'(o_bus_wdat), 64'(wdat));
          chk("cmd_wen", 64'(o_bus_wen), 64'(ren ? 4'd0 : wen));
          chk("cmd_read", 64'(o_bus_read), 64'(ren));
          chk("cmd_rsp_rdy", 64'(o_bus_rsp_rdy), 64'd0);
          if (cmd_cnt == stall + 1) begin
            i_bus_cmd_rdy = 1'b1; drove_rdy = 1;
          end
        end
        if (off >= 0) begin
          chk("rsp_rdy", 64'(o_bus_rsp_rdy), 64'd1);
          if (off == d) i_bus_rsp_val = 1'b1;
        end
      end
      last_cmd = o_bus_cmd_val;
    end
    chk("rdy_seen", 64'(done), 64'd1);
    @(posedge clk); @(negedge clk);
    chk("rdy_one_cycle", 64'(hs_ls4ex_rdy), 64'd0);
    chk("post_outs", {31'd0, o_ls_err, o_ls_rdat}, 64'd0);
    chk("post_rsp_rdy", 64'(o_bus_rsp_rdy), 64'd1);
  endtask

  // Drive a response while idle and confirm it has no effect.
  task automatic stray_rsp(input logic [31:0] junk);
    hs_ex4ls_val = 1'b0;
    i_bus_rsp_val = 1'b1; i_bus_rdat = junk; i_bus_err = 1'b1;
    @(posedge clk); @(negedge clk);
    i_bus_rsp_val = 1'b0;
    chk("stray_rdy", 64'(hs_ls4ex_rdy), 64'd0);
    chk("stray_cmd", 64'(o_bus_cmd_val), 64'd0);
    chk("stray_outs", {31'd0, o_ls_err, o_ls_rdat}, 64'd0);
  endtask

  initial begin
    logic [3:0] rw;
    rst_n = 1'b0;
    hs_ex4ls_val = 1'b0; i_ls_adr = '0; i_ls_wdat = '0; i_ls_wen = '0; i_ls_ren = 1'b0;
    i_bus_cmd_rdy = 1'b0; i_bus_rsp_val = 1'b0; i_bus_rdat = '0; i_bus_err = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait load.
    do_access(32'h100, 32'h0, 4'b0000, 1'b1, 0, 0, 32'hDEADBEEF, 1'b0);
    // Store with command stalled three cycles.
    do_access(32'h204, 32'h1234, 4'b0011, 1'b0, 3, 0, 32'hCAFEF00D, 1'b0);
    // Illegal and no-op requests.
    do_access(32'h300, 32'h55, 4'b0001, 1'b1, 0, 0, 32'h0, 1'b0);
    do_access(32'h304, 32'h66, 4'b0000, 1'b0, 0, 0, 32'h0, 1'b0);
    // Timeout, then a late response in idle, then a normal load.
    do_access(32'h400, 32'h0, 4'b0000, 1'b1, 0, 99, 32'h11111111, 1'b0);
    stray_rsp(32'hBADBAD00);
    do_access(32'h404, 32'h0, 4'b0000, 1'b1, 1, 2, 32'h0BADF00D, 1'b0);
    // Response exactly at the expiry cycle wins.
    do_access(32'h408, 32'h0, 4'b0000, 1'b1, 0, TO - 1, 32'h76543210, 1'b0);
    // Bus error on a load returns the bus data with err.
    do_access(32'h500, 32'h0, 4'b0000, 1'b1, 0, 1, 32'hA5A5A5A5, 1'b1);

    // Reset while waiting in RSP.
    hs_ex4ls_val = 1'b1; i_ls_adr = 32'h600; i_ls_wen = 4'd0; i_ls_ren = 1'b1;
    @(posedge clk); @(negedge clk);
    i_bus_cmd_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    i_bus_cmd_rdy = 1'b0;
    rst_n = 1'b0; hs_ex4ls_val = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk); rst_n = 1'b1;
    stray_rsp(32'h12345678);
    do_access(32'h604, 32'h0, 4'b0000, 1'b1, 0, 0, 32'h600D600D, 1'b0);

    // Randomized accesses against the reference outcome.
    for (int n = 0; n < 24; n++) begin
      rw = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      do_access($urandom, $urandom, rw, 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
